// File: rtl/unflatten_stream_if.sv
// Handshake bundle between the FCL backward stream, unflatten_stream and the maxpool backward stage.
// The slave modport is the unflatten block's view; master is the surrounding environment.
interface unflatten_stream_if #(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 2,
    parameter int DIM3_WIDTH  = 4,
    parameter int DIM3_HEIGHT = 4,
    parameter int DIM1_LENGTH = CHANNELS * DIM3_WIDTH * DIM3_HEIGHT
);
    localparam int FC_W = $clog2(DIM1_LENGTH + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_last;
    logic signed [WIDTH-1:0] output_3D_maxpool_matrix [0:CHANNELS-1][0:DIM3_HEIGHT-1][0:DIM3_WIDTH-1];
    logic                    out_valid;
    logic                    out_ack;
    logic                    frame_err;
    logic [FC_W-1:0]         fill_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ack,
        output in_ready, output_3D_maxpool_matrix, out_valid, frame_err, fill_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ack,
        input  in_ready, output_3D_maxpool_matrix, out_valid, frame_err, fill_count
    );
endinterface

// File: rtl/unflatten_stream.sv
// Scatters a 1D gradient stream (one element per beat) into a registered [ch][row][col] frame
// and holds the completed frame for the maxpool backward stage until acknowledged.
module unflatten_stream #(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 2,
    parameter int DIM3_WIDTH  = 4,
    parameter int DIM3_HEIGHT = 4,
    parameter int DIM1_LENGTH = CHANNELS * DIM3_WIDTH * DIM3_HEIGHT
) (
    input  logic               clk,
    input  logic               rst,
    unflatten_stream_if.slave  bus
);
    localparam int FC_W  = $clog2(DIM1_LENGTH + 1);
    localparam int COL_W = (DIM3_WIDTH  > 1) ? $clog2(DIM3_WIDTH)  : 1;
    localparam int ROW_W = (DIM3_HEIGHT > 1) ? $clog2(DIM3_HEIGHT) : 1;
    localparam int CH_W  = (CHANNELS    > 1) ? $clog2(CHANNELS)    : 1;

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [FC_W-1:0]         fill_q, fill_d;
    logic                    out_valid_q, out_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic signed [WIDTH-1:0] buf_q [0:CHANNELS-1][0:DIM3_HEIGHT-1][0:DIM3_WIDTH-1];

    logic in_ready;
    logic beat;
    logic at_end;

    assign at_end = (fill_q == FC_W'(DIM1_LENGTH - 1));

    // State register and pointer/status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state: pointer advance, frame completion and length-mismatch detection
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        ch_d        = ch_q;
        fill_d      = fill_q;
        frame_err_d = 1'b0;
        case (state_q)
            FILL: begin
                if (beat) begin
                    if (at_end != bus.in_last) begin
                        frame_err_d = 1'b1;
                        col_d       = '0;
                        row_d       = '0;
                        ch_d        = '0;
                        fill_d      = '0;
                    end else if (at_end) begin
                        state_d = HOLD;
                        col_d   = '0;
                        row_d   = '0;
                        ch_d    = '0;
                        fill_d  = '0;
                    end else begin
                        fill_d = fill_q + FC_W'(1);
                        if (col_q == COL_W'(DIM3_WIDTH - 1)) begin
                            col_d = '0;
                            if (row_q == ROW_W'(DIM3_HEIGHT - 1)) begin
                                row_d = '0;
                                ch_d  = ch_q + CH_W'(1);
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.out_ack) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
        out_valid_d = (state_d == HOLD);
    end

    // Outputs: ready is combinational so reset blocks acceptance in the same cycle
    always_comb begin
        in_ready = (state_q == FILL) && !rst;
        beat     = bus.in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int r = 0; r < DIM3_HEIGHT; r++)
                    for (int k = 0; k < DIM3_WIDTH; k++)
                        buf_q[c][r][k] <= '0;
        end else if (beat) begin
            buf_q[ch_q][row_q][col_q] <= bus.in_data;
        end
    end

    assign bus.in_ready                 = in_ready;
    assign bus.out_valid                = out_valid_q;
    assign bus.frame_err                = frame_err_q;
    assign bus.fill_count               = fill_q;
    assign bus.output_3D_maxpool_matrix = buf_q;
endmodule
